// File: rtl/compare_div_pkg.sv
// rtl/compare_div_pkg.sv - shared widths, state encoding and iteration count for the divider back-check
package compare_div_pkg;

  localparam int A_W      = 16;  // dividend and product width
  localparam int B_W      = 8;   // divisor width
  localparam int Q_W      = 8;   // quotient width
  localparam int ITER_CNT = Q_W; // one shift-add iteration per quotient bit

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/quotient_reconstructor_if.sv
// rtl/quotient_reconstructor_if.sv - request/result bundle for the quotient back-check
// Ports (master = requester, slave = quotient_reconstructor):
//   start, a, b, q             : request and operands, driven by master
//   busy, done, prod, resid,
//   ok, bz                     : status and results, driven by slave
interface quotient_reconstructor_if #(
  parameter int A_W = compare_div_pkg::A_W,
  parameter int B_W = compare_div_pkg::B_W,
  parameter int Q_W = compare_div_pkg::Q_W
);

  logic           start;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic [Q_W-1:0] q;
  logic           busy;
  logic           done;
  logic [A_W-1:0] prod;
  logic [A_W:0]   resid;
  logic           ok;
  logic           bz;

  modport master (
    output start, a, b, q,
    input  busy, done, prod, resid, ok, bz
  );

  modport slave (
    input  start, a, b, q,
    output busy, done, prod, resid, ok, bz
  );

endinterface

// File: rtl/shift_add_step.sv
// rtl/shift_add_step.sv - one combinational shift-add multiply iteration
// Ports:
//   acc, b_sh, q_sh            : current accumulator, shifted divisor, shifted quotient
//   acc_n, b_sh_n, q_sh_n      : values after this iteration
module shift_add_step
  import compare_div_pkg::*;
(
  input  logic [A_W-1:0] acc,
  input  logic [A_W-1:0] b_sh,
  input  logic [Q_W-1:0] q_sh,
  output logic [A_W-1:0] acc_n,
  output logic [A_W-1:0] b_sh_n,
  output logic [Q_W-1:0] q_sh_n
);

  // 255*255 fits in A_W bits, so the add never wraps for legal operands.
  assign acc_n  = q_sh[0] ? (acc + b_sh) : acc;
  assign b_sh_n = b_sh << 1;
  assign q_sh_n = q_sh >> 1;

endmodule

// File: rtl/quotient_reconstructor.sv
// rtl/quotient_reconstructor.sv - rebuilds q*b and reports residual a-q*b and exact-floor flag
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : quotient_reconstructor_if.slave (start/a/b/q in; busy/done/prod/resid/ok/bz out)
module quotient_reconstructor
  import compare_div_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  quotient_reconstructor_if.slave   bus
);

  localparam int CNT_W = $clog2(ITER_CNT + 1);

  state_t         state, state_n;

  logic [A_W-1:0] a_r;
  logic [B_W-1:0] b_r;
  logic [A_W-1:0] acc, b_sh;
  logic [Q_W-1:0] q_sh;
  logic [CNT_W-1:0] cnt;

  logic [A_W-1:0] acc_n, b_sh_n;
  logic [Q_W-1:0] q_sh_n;

  logic           busy_r, done_r, ok_r, bz_r;
  logic [A_W-1:0] prod_r;
  logic [A_W:0]   resid_r;

  logic           last_iter;
  logic [A_W:0]   resid_c;
  logic           bz_c, ok_c;

  shift_add_step u_step (
    .acc    (acc),
    .b_sh   (b_sh),
    .q_sh   (q_sh),
    .acc_n  (acc_n),
    .b_sh_n (b_sh_n),
    .q_sh_n (q_sh_n)
  );

  assign last_iter = (cnt == CNT_W'(ITER_CNT - 1));

  // Residual is computed one bit wider so an over-large quotient shows up negative.
  assign resid_c = {1'b0, a_r} - {1'b0, acc};
  assign bz_c    = (b_r == '0);
  assign ok_c    = !bz_c && !resid_c[A_W] && (resid_c < {{(A_W + 1 - B_W){1'b0}}, b_r});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // busy mirrors "not in IDLE", so checking for IDLE is the same as sampling
  // start only while busy is low.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = (bus.b == '0) ? FIN : MUL;
      MUL:     if (last_iter) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      acc  <= '0;
      b_sh <= '0;
      q_sh <= '0;
      cnt  <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        a_r  <= bus.a;
        b_r  <= bus.b;
        b_sh <= A_W'(bus.b);
        q_sh <= bus.q;
        acc  <= '0;
        cnt  <= '0;
      end else if (state == MUL) begin
        acc  <= acc_n;
        b_sh <= b_sh_n;
        q_sh <= q_sh_n;
        cnt  <= cnt + 1'b1;
      end
    end
  end

  // Results only change in FIN; they hold across IDLE/MUL until the next done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      prod_r  <= '0;
      resid_r <= '0;
      ok_r    <= 1'b0;
      bz_r    <= 1'b0;
    end else begin
      busy_r <= (state_n != IDLE);
      done_r <= (state == FIN);
      if (state == FIN) begin
        prod_r  <= acc;
        resid_r <= resid_c;
        ok_r    <= ok_c;
        bz_r    <= bz_c;
      end
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.prod  = prod_r;
  assign bus.resid = resid_r;
  assign bus.ok    = ok_r;
  assign bus.bz    = bz_r;

endmodule

// File: tb/tb_quotient_reconstructor.sv
// tb/tb_quotient_reconstructor.sv - directed self-checking bench for quotient_reconstructor
module tb_quotient_reconstructor;

  logic clk;
  logic rst;

  quotient_reconstructor_if bus ();

  quotient_reconstructor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Drives the request so that the next rising edge (edge k) samples it.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b, input logic [7:0] q);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.q     = q;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after edge k until done is seen; bounded.
  task automatic wait_done(input string tag, output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) seen = 1;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      lat = -1;
    end else begin
      check({tag, "_busy_low_at_done"}, 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic run_and_check(input string tag,
                               input logic [15:0] a, input logic [7:0] b, input logic [7:0] q,
                               input int exp_lat, input logic [15:0] exp_prod,
                               input logic [16:0] exp_resid, input logic exp_ok, input logic exp_bz);
    int lat;
    start_op(a, b, q);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(tag, lat);
    check({tag, "_lat"},   32'(lat),       32'(exp_lat));
    check({tag, "_prod"},  32'(bus.prod),  32'(exp_prod));
    check({tag, "_resid"}, 32'(bus.resid), 32'(exp_resid));
    check({tag, "_ok"},    32'(bus.ok),    32'(exp_ok));
    check({tag, "_bz"},    32'(bus.bz),    32'(exp_bz));
    @(posedge clk);
    #1;
    check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int lat2;
    bit seen;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.q     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_prod",  32'(bus.prod),  32'd0);
    check("rst_resid", 32'(bus.resid), 32'd0);
    check("rst_ok",    32'(bus.ok),    32'd0);
    check("rst_bz",    32'(bus.bz),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_and_check("exact",  16'd1000,  8'd7,   8'd142, 9, 16'd994,   17'd6,      1'b1, 1'b0);
    run_and_check("over",   16'd1000,  8'd7,   8'd143, 9, 16'd1001,  17'h1FFFF,  1'b0, 1'b0);
    run_and_check("bzero",  16'd500,   8'd0,   8'd9,   1, 16'd0,     17'd500,    1'b0, 1'b1);
    run_and_check("maxop",  16'd65535, 8'd255, 8'd255, 9, 16'd65025, 17'd510,    1'b0, 1'b0);

    // Busy-time start is ignored; start held through done is taken the next edge.
    start_op(16'd1000, 8'd7, 8'd142);
    seen = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) begin
        bus.start = 1'b1;
        bus.a = 16'd9;
        bus.b = 8'd3;
        bus.q = 8'd1;
      end else if (i == 5) begin
        bus.start = 1'b0;
      end
      if (i == 8) begin
        bus.start = 1'b1;
        bus.a = 16'd255;
        bus.b = 8'd16;
        bus.q = 8'd15;
      end
      if (i == 9) seen = bus.done;
    end
    check("b2b_first_done",  32'(seen),      32'd1);
    check("b2b_first_prod",  32'(bus.prod),  32'd994);
    check("b2b_first_resid", 32'(bus.resid), 32'd6);
    check("b2b_first_ok",    32'(bus.ok),    32'd1);
    lat2 = 0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat2++;
      if (lat2 == 1) begin
        bus.start = 1'b0;
        check("b2b_accept_busy", 32'(bus.busy), 32'd1);
        check("b2b_hold_prod",   32'(bus.prod), 32'd994);
      end
      if (bus.done) seen = 1;
    end
    check("b2b_second_seen",  32'(seen),      32'd1);
    check("b2b_spacing",      32'(lat2),      32'd10);
    check("b2b_second_prod",  32'(bus.prod),  32'd240);
    check("b2b_second_resid", 32'(bus.resid), 32'd15);
    check("b2b_second_ok",    32'(bus.ok),    32'd1);

    // Asynchronous reset in the middle of the multiply.
    start_op(16'd1000, 8'd7, 8'd142);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_busy",  32'(bus.busy),  32'd0);
    check("arst_done",  32'(bus.done),  32'd0);
    check("arst_prod",  32'(bus.prod),  32'd0);
    check("arst_resid", 32'(bus.resid), 32'd0);
    check("arst_ok",    32'(bus.ok),    32'd0);
    check("arst_bz",    32'(bus.bz),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_and_check("post_rst", 16'd100, 8'd10, 8'd10, 9, 16'd100, 17'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
